// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector: luma weights,
// output mode encodings and the fixed input-to-output latency.
package sobel_pkg;

    localparam int LUMA_R   = 54;
    localparam int LUMA_G   = 183;
    localparam int LUMA_B   = 18;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        MODE_MAG       = 2'b00,
        MODE_MAG_FLOOR = 2'b01,
        MODE_BINARY    = 2'b10,
        MODE_LUMA      = 2'b11
    } mode_e;

    // Weights sum to 255, so the shifted result never exceeds 254.
    function automatic logic [7:0] rgb_to_luma(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'(LUMA_R * rgb[23:16] + LUMA_G * rgb[15:8] + LUMA_B * rgb[7:0]);
        return acc[15:8];
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line luma store for the 3x3 window. The row above is read and shifted
// into the older row on every write; reads see the pre-write contents.
module sobel_line_buf #(
    parameter int DEPTH  = 640,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_up1,
    output logic [PIX_W-1:0]  rd_up2
);

    logic [PIX_W-1:0] row_a [DEPTH];
    logic [PIX_W-1:0] row_b [DEPTH];

    assign rd_up1 = row_a[addr];
    assign rd_up2 = row_b[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_a[addr] <= wr_data;
            row_b[addr] <= row_a[addr];
        end
    end

endmodule

// File: rtl/sobel_edge_pipe.sv
// Streaming 3x3 Sobel detector: luma + window (S1), gradients (S2),
// magnitude/mode select (S3). Framing rides a matching 3-deep delay line.
module sobel_edge_pipe
    import sobel_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 10,
    parameter int THRESH_DEF = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [23:0]      in_rgb,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] thresh,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [PIX_W-1:0] out_pix,
    output logic             line_err
);

    localparam int GW = PIX_W + 3;

    logic              synced;
    logic [ADDR_W-1:0] col;
    logic [10:0]       row;
    mode_e             mode_act;
    logic [PIX_W-1:0]  thr_act;
    logic [PIPE_LAT-1:0] v_pipe, sof_pipe, eol_pipe;

    logic              accept, last_col, wrap;
    logic [ADDR_W-1:0] cur_col;
    logic [10:0]       cur_row;
    logic [7:0]        y8;
    logic [PIX_W-1:0]  luma, rd_up1, rd_up2;

    assign accept   = in_valid && (synced || in_sof);
    assign cur_col  = in_sof ? '0 : col;
    assign cur_row  = in_sof ? '0 : row;
    assign last_col = (cur_col == ADDR_W'(IMG_W - 1));
    assign wrap     = in_eol || last_col;
    assign y8       = rgb_to_luma(in_rgb);
    assign luma     = y8[7 -: PIX_W];

    sobel_line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_line_buf (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (luma),
        .rd_up1  (rd_up1),
        .rd_up2  (rd_up2)
    );

    // Datapath stages carry no reset; v_pipe marks which stage contents matter.
    logic [PIX_W-1:0]     win [9];
    logic                 border1, border2;
    mode_e                mode1, mode2;
    logic [PIX_W-1:0]     thr1, thr2, centre2;
    logic signed [GW-1:0] gx, gy, gx_n, gy_n;
    logic signed [GW-1:0] e [9];
    logic [GW-1:0]        ax, ay, mag;
    logic [PIX_W-1:0]     sat, result;

    always_comb begin
        for (int i = 0; i < 9; i++) e[i] = $signed({3'b000, win[i]});
        gx_n = (e[2] - e[0]) + ((e[5] - e[3]) <<< 1) + (e[8] - e[6]);
        gy_n = (e[0] - e[6]) + ((e[1] - e[7]) <<< 1) + (e[2] - e[8]);
    end

    always_comb begin
        ax  = gx[GW-1] ? -gx : gx;
        ay  = gy[GW-1] ? -gy : gy;
        mag = ax + ay;
        sat = (|mag[GW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
        result = '0;
        case (mode2)
            MODE_MAG:       result = sat;
            MODE_MAG_FLOOR: result = (sat <= thr2) ? '0 : sat;
            MODE_BINARY:    result = (sat > thr2) ? '1 : '0;
            MODE_LUMA:      result = centre2;
            default:        result = '0;
        endcase
        if (mode2 != MODE_LUMA && border2) result = '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win[0] <= win[1];  win[1] <= win[2];  win[2] <= rd_up2;
            win[3] <= win[4];  win[4] <= win[5];  win[5] <= rd_up1;
            win[6] <= win[7];  win[7] <= win[8];  win[8] <= luma;
            border1 <= (cur_row < 11'd2) || (cur_col < ADDR_W'(2));
            mode1   <= in_sof ? mode_e'(mode) : mode_act;
            thr1    <= in_sof ? thresh : thr_act;
        end
        gx      <= gx_n;
        gy      <= gy_n;
        border2 <= border1;
        mode2   <= mode1;
        thr2    <= thr1;
        centre2 <= win[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            synced   <= 1'b0;
            col      <= '0;
            row      <= '0;
            mode_act <= MODE_MAG_FLOOR;
            thr_act  <= PIX_W'(THRESH_DEF);
            v_pipe   <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
            out_pix  <= '0;
            line_err <= 1'b0;
        end else begin
            v_pipe   <= {v_pipe[PIPE_LAT-2:0], accept};
            sof_pipe <= {sof_pipe[PIPE_LAT-2:0], accept && in_sof};
            eol_pipe <= {eol_pipe[PIPE_LAT-2:0], accept && in_eol};
            out_pix  <= v_pipe[PIPE_LAT-2] ? result : '0;
            line_err <= accept && (in_eol != last_col);
            if (accept) begin
                if (in_sof) begin
                    synced   <= 1'b1;
                    mode_act <= mode_e'(mode);
                    thr_act  <= thresh;
                end
                if (wrap) begin
                    col <= '0;
                    row <= (cur_row == 11'd2047) ? cur_row : cur_row + 11'd1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    assign out_valid = v_pipe[PIPE_LAT-1];
    assign out_sof   = sof_pipe[PIPE_LAT-1];
    assign out_eol   = eol_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Bench for sobel_edge_pipe on an 8-pixel-wide image: a frame-array reference
// model feeds an expectation queue that is compared every clock.
module tb_sobel_edge_pipe;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sof, in_eol;
    logic [23:0] in_rgb;
    logic [1:0]  mode;
    logic [7:0]  thresh;
    logic        out_valid, out_sof, out_eol, line_err;
    logic [7:0]  out_pix;

    always #5 clk = ~clk;

    sobel_edge_pipe #(.IMG_W(W), .PIX_W(8), .ADDR_W(3), .THRESH_DEF(19)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_rgb(in_rgb), .mode(mode), .thresh(thresh), .out_valid(out_valid),
        .out_sof(out_sof), .out_eol(out_eol), .out_pix(out_pix), .line_err(line_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit run     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit sof;
        bit eol;
        bit chk;
        int pix;
        int lit;
    } exp_t;

    exp_t q[$];
    int   lq[$];

    bit m_synced;
    int m_row, m_col, m_mode, m_thr;
    int lum[16][W];
    bit known[16][W];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int luma_of(input logic [23:0] rgb);
        return (54 * int'(rgb[23:16]) + 183 * int'(rgb[15:8]) + 18 * int'(rgb[7:0])) / 256;
    endfunction

    // Window p0..p8 in raster order, p4 is the centre pixel.
    function automatic int sobel_ref(input int p[9], input int md, input int th);
        int gx, gy, mag, sat;
        gx  = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        gy  = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat = (mag > 255) ? 255 : mag;
        case (md)
            0:       return sat;
            1:       return (sat <= th) ? 0 : sat;
            2:       return (sat > th) ? 255 : 0;
            default: return p[4];
        endcase
    endfunction

    task automatic model_pixel(input bit sof, input bit eol, input logic [23:0] rgb,
                               input int lit_r, input int lit_c, input int lit_v);
        exp_t e;
        int   r, c, p[9];
        bit   ok;
        if (!(m_synced || sof)) return;
        if (sof) begin
            m_synced = 1; m_row = 0; m_col = 0; m_mode = mode; m_thr = thresh;
            for (int i = 0; i < 16; i++) for (int j = 0; j < W; j++) known[i][j] = 0;
        end
        r = m_row; c = m_col;
        e.cyc = cyc; e.sof = sof; e.eol = eol; e.chk = 0; e.pix = 0;
        e.lit = (r == lit_r && c == lit_c) ? lit_v : -1;
        if (r < 16) begin lum[r][c] = luma_of(rgb); known[r][c] = 1; end
        if (m_mode != 3 && (r < 2 || c < 2)) begin
            e.chk = 1;
        end else if (r < 16 && m_mode == 3) begin
            e.chk = (r >= 1 && c >= 1) ? known[r-1][c-1] : 0;
            if (e.chk) e.pix = lum[r-1][c-1];
        end else if (r < 16) begin
            ok = 1;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    ok = ok & known[r-2+i][c-2+j];
                    p[i*3+j] = lum[r-2+i][c-2+j];
                end
            e.chk = ok;
            if (ok) e.pix = sobel_ref(p, m_mode, m_thr);
        end
        q.push_back(e);
        if ((eol && c != W-1) || (!eol && c == W-1)) lq.push_back(cyc + 1);
        if (eol || c == W-1) begin
            m_col = 0;
            m_row = (r < 2047) ? r + 1 : 2047;
        end else begin
            m_col = c + 1;
        end
    endtask

    task automatic drive_pixel(input bit sof, input bit eol, input logic [23:0] rgb,
                               input int lit_r, input int lit_c, input int lit_v);
        @(negedge clk); #1;
        in_valid = 1; in_sof = sof; in_eol = eol; in_rgb = rgb;
        model_pixel(sof, eol, rgb, lit_r, lit_c, lit_v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            in_valid = 0; in_sof = 0; in_eol = 0;
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk); #1;
        rst = 1; in_valid = 0; in_sof = 0; in_eol = 0;
        q.delete(); lq.delete(); m_synced = 0;
        repeat (n) @(negedge clk);
        #1 rst = 0;
    endtask

    function automatic logic [23:0] color(input int kind, input int c);
        case (kind)
            0:       return 24'h808080;
            1:       return (c >= 4) ? 24'hFFFFFF : 24'h000000;
            default: return (c >= 4) ? 24'h000700 : 24'h000000;
        endcase
    endfunction

    // kind 0 grey, 1 black/white step at col 4, 2 step of luma 5 at col 4.
    task automatic run_frame(input int kind, input int rows, input bit do_sof,
                             input int short_row, input int short_col, input int noeol_row,
                             input int lit_r, input int lit_c, input int lit_v);
        int last;
        for (int r = 0; r < rows; r++) begin
            last = (r == short_row) ? short_col : W - 1;
            for (int c = 0; c <= last; c++)
                drive_pixel(do_sof && r == 0 && c == 0, (c == last) && (r != noeol_row),
                            color(kind, c), lit_r, lit_c, lit_v);
            idle(1);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   exp_v, exp_l;
        if (run) begin
            exp_v = (q.size() > 0) && (q[0].cyc + 3 == cyc);
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                e = q.pop_front();
                check("out_sof", out_sof, e.sof);
                check("out_eol", out_eol, e.eol);
                if (e.chk) check("out_pix", out_pix, e.pix);
                if (e.lit >= 0) check("lit_pix", out_pix, e.lit);
            end
            exp_l = (lq.size() > 0) && (lq[0] == cyc);
            if (exp_l) void'(lq.pop_front());
            check("line_err", line_err, exp_l);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int p[9];
        rst = 1; in_valid = 0; in_sof = 0; in_eol = 0; in_rgb = '0; mode = 0; thresh = 0;

        check("pin_luma_grey", luma_of(24'h808080), 127);
        check("pin_luma_white", luma_of(24'hFFFFFF), 254);
        check("pin_luma_g7", luma_of(24'h000700), 5);
        p = '{0, 0, 254, 0, 0, 254, 0, 0, 254};
        check("pin_step_mag", sobel_ref(p, 0, 0), 255);
        check("pin_step_bin", sobel_ref(p, 2, 254), 255);
        p = '{0, 5, 5, 0, 5, 5, 0, 5, 5};
        check("pin_ramp_floor19", sobel_ref(p, 1, 19), 20);
        check("pin_ramp_floor20", sobel_ref(p, 1, 20), 0);

        apply_reset(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eol", out_eol, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_line_err", line_err, 0);
        run = 1;

        for (int i = 0; i < 6; i++) drive_pixel(0, i == 5, 24'h808080, -1, -1, -1);
        idle(2);

        mode = 0;            run_frame(0, 4, 1, -1, -1, -1, 3, 4, 0);
        mode = 3;            run_frame(0, 3, 1, -1, -1, -1, 2, 3, 127);
        mode = 0;            run_frame(1, 4, 1, -1, -1, -1, 3, 4, 255);
        mode = 2; thresh = 254; run_frame(1, 4, 1, -1, -1, -1, 2, 5, 255);
        mode = 1; thresh = 19;  run_frame(2, 3, 1, -1, -1, -1, 2, 4, 20);
        thresh = 20;         run_frame(2, 3, 1, -1, -1, -1, 2, 5, 0);

        mode = 0; thresh = 19; run_frame(2, 2, 1, -1, -1, -1, -1, -1, -1);
        mode = 2;            run_frame(2, 2, 0, -1, -1, -1, 3, 4, 20);
        run_frame(2, 3, 1, -1, -1, -1, 2, 4, 255);

        mode = 0;            run_frame(1, 5, 1, 1, 5, 3, 3, 4, 255);

        drive_pixel(1, 1, 24'h808080, -1, -1, -1);
        run_frame(1, 3, 0, -1, -1, -1, 3, 4, 255);

        run_frame(1, 2, 1, -1, -1, -1, -1, -1, -1);
        run_frame(1, 1, 0, 0, 2, -1, -1, -1, -1);
        run_frame(1, 4, 1, -1, -1, -1, 3, 5, 255);

        for (int i = 0; i < 4; i++) drive_pixel(i == 0, 0, 24'h808080, -1, -1, -1);
        apply_reset(2);
        for (int i = 0; i < 5; i++) drive_pixel(0, 0, 24'hFFFFFF, -1, -1, -1);
        idle(4);
        run_frame(1, 3, 1, -1, -1, -1, 2, 4, 255);

        idle(8);
        check("drain_pixels", q.size(), 0);
        check("drain_line_err", lq.size(), 0);
        run = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
